// File: rtl/vrf_pkg.sv
// Shared field widths and request/response bundles for the VRF read path.
package vrf_pkg;

    localparam int VS_W     = 5;
    localparam int OFFSET_W = 2;
    localparam int SRC_W    = 2;
    localparam int IDX_W    = 3;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [VS_W-1:0]     vs;
        logic [SRC_W-1:0]    readSource;
        logic [OFFSET_W-1:0] offset;
        logic [IDX_W-1:0]    instructionIndex;
    } vrf_read_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  readSource;
        logic [IDX_W-1:0]  instructionIndex;
    } vrf_read_resp_t;

endpackage

// File: rtl/vrf_resp_fifo.sv
// Circular response FIFO with occupancy count; storage is not reset, only pointers and count.
module vrf_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths stay correct.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vrf_read_responder.sv
// Accepts VRF read requests, issues them to the fixed-latency SRAM bank and returns
// tagged data through a credit-limited response queue.
module vrf_read_responder
    import vrf_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     req_ready,
    input  logic                     req_valid,
    input  logic [VS_W-1:0]          req_vs,
    input  logic [SRC_W-1:0]         req_readSource,
    input  logic [OFFSET_W-1:0]      req_offset,
    input  logic [IDX_W-1:0]         req_instructionIndex,
    input  logic                     write_busy,
    output logic                     sram_re,
    output logic [VS_W+OFFSET_W-1:0] sram_addr,
    input  logic [DATA_W-1:0]        sram_rdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_data,
    output logic [SRC_W-1:0]         resp_readSource,
    output logic [IDX_W-1:0]         resp_instructionIndex
);

    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int CRD_W  = CNT_W + 1;
    localparam int RESP_W = $bits(vrf_read_resp_t);

    typedef struct packed {
        logic [SRC_W-1:0] readSource;
        logic [IDX_W-1:0] instructionIndex;
    } tag_t;

    vrf_read_req_t         req;
    logic                  run_q;
    logic                  fire;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      count;
    logic [CRD_W-1:0]      credit;
    logic [READ_LATENCY:1] vld_p;
    tag_t                  tag_p [1:READ_LATENCY];
    vrf_read_resp_t        push_data;
    vrf_read_resp_t        pop_data;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign req = '{vs:               req_vs,
                   readSource:       req_readSource,
                   offset:           req_offset,
                   instructionIndex: req_instructionIndex};

    // Credit counts every slot already promised to a read, so the queue can never overflow.
    assign credit    = CRD_W'(inflight) + CRD_W'(count);
    assign req_ready = run_q && !write_busy && !fifo_full && (credit < CRD_W'(RESP_DEPTH));
    assign fire      = req_valid && req_ready;
    assign sram_re   = fire;
    assign sram_addr = {req.vs, req.offset};

    // Holds req_ready low through reset and until the first edge after release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Stage 1..READ_LATENCY: tag travels with the read through the SRAM latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p <= '0;
        end else begin
            vld_p[1] <= fire;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        tag_p[1] <= '{readSource: req.readSource, instructionIndex: req.instructionIndex};
        for (int i = 2; i <= READ_LATENCY; i++) begin
            tag_p[i] <= tag_p[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            case ({fire, vld_p[READ_LATENCY]})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Final stage: SRAM data meets its tag and is written into the response queue.
    assign fifo_push = vld_p[READ_LATENCY];
    assign push_data = '{data:             sram_rdata,
                         readSource:       tag_p[READ_LATENCY].readSource,
                         instructionIndex: tag_p[READ_LATENCY].instructionIndex};
    assign fifo_pop  = resp_valid && resp_ready;

    vrf_resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign resp_valid            = !fifo_empty;
    assign resp_data             = pop_data.data;
    assign resp_readSource       = pop_data.readSource;
    assign resp_instructionIndex = pop_data.instructionIndex;

endmodule

// File: tb/tb_vrf_read_responder.sv
// Directed bench for vrf_read_responder with a two-cycle synchronous SRAM model.
module tb_vrf_read_responder;
    import vrf_pkg::*;

    localparam int RL    = 2;
    localparam int DEPTH = 4;
    localparam int AW    = VS_W + OFFSET_W;
    localparam int RW    = DATA_W + SRC_W + IDX_W + 1;

    logic                clock = 1'b0;
    logic                reset;
    logic                req_ready;
    logic                req_valid;
    logic [VS_W-1:0]     req_vs;
    logic [SRC_W-1:0]    req_readSource;
    logic [OFFSET_W-1:0] req_offset;
    logic [IDX_W-1:0]    req_instructionIndex;
    logic                write_busy;
    logic                sram_re;
    logic [AW-1:0]       sram_addr;
    logic [DATA_W-1:0]   sram_rdata;
    logic                resp_valid;
    logic                resp_ready;
    logic [DATA_W-1:0]   resp_data;
    logic [SRC_W-1:0]    resp_readSource;
    logic [IDX_W-1:0]    resp_instructionIndex;
    logic [AW-1:0]       a1;
    logic [AW-1:0]       a2;
    logic [RW-1:0]       obs_resp;

    int total = 0;
    int bad   = 0;

    vrf_read_responder #(.READ_LATENCY(RL), .RESP_DEPTH(DEPTH)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .req_ready             (req_ready),
        .req_valid             (req_valid),
        .req_vs                (req_vs),
        .req_readSource        (req_readSource),
        .req_offset            (req_offset),
        .req_instructionIndex  (req_instructionIndex),
        .write_busy            (write_busy),
        .sram_re               (sram_re),
        .sram_addr             (sram_addr),
        .sram_rdata            (sram_rdata),
        .resp_valid            (resp_valid),
        .resp_ready            (resp_ready),
        .resp_data             (resp_data),
        .resp_readSource       (resp_readSource),
        .resp_instructionIndex (resp_instructionIndex)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] sram_val(input logic [AW-1:0] addr);
        if (addr == 7'h0D) return 32'hDEADBEEF;
        return 32'h5A00_0000 | {18'h0, addr, addr};
    endfunction

    always @(posedge clock) begin
        if (sram_re) a1 <= sram_addr;
        a2 <= a1;
    end
    assign sram_rdata = sram_val(a2);
    assign obs_resp   = {resp_valid, resp_data, resp_readSource, resp_instructionIndex};

    // Request k carries vs=k+4, offset=k%4, src=k%4, idx=k%8.
    function automatic logic [VS_W-1:0] k_vs(input int k);
        return VS_W'(k + 4);
    endfunction
    function automatic logic [AW-1:0] k_addr(input int k);
        return {k_vs(k), OFFSET_W'(k)};
    endfunction
    function automatic logic [RW-1:0] exp_resp(input int k);
        return {1'b1, sram_val(k_addr(k)), SRC_W'(k), IDX_W'(k)};
    endfunction

    task automatic drive_req(input int k);
        req_vs               = k_vs(k);
        req_offset           = OFFSET_W'(k);
        req_readSource       = SRC_W'(k);
        req_instructionIndex = IDX_W'(k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            write_busy = 1'b0;
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1 && dut.fifo_push === 1'b1 && dut.fifo_full === 1'b1) begin
            bad++;
            $display("FAIL push_when_full got=1 want=0 at %0t", $time);
        end
    end

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b1; write_busy = 1'b0; resp_ready = 1'b1;
        drive_req(0);
        #2;
        total++;
        if ({req_ready, sram_re, resp_valid} !== 3'b000) begin
            bad++; $display("FAIL reset_outputs got=%b want=000", {req_ready, sram_re, resp_valid});
        end
        repeat (2) @(negedge clock);
        reset = 1'b1; req_valid = 1'b0;
        idle(2);
        #1;
        total++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            bad++; $display("FAIL reset_release got=%b want=10", {req_ready, resp_valid});
        end
    endtask

    task automatic test_single();
        @(negedge clock);
        resp_ready = 1'b1; req_valid = 1'b1;
        req_vs = 5'd3; req_offset = 2'd1; req_readSource = 2'd2; req_instructionIndex = 3'd5;
        #1;
        total++;
        if ({req_ready, sram_re, sram_addr} !== {2'b11, 7'h0D}) begin
            bad++; $display("FAIL single_accept got=%h want=%h", {req_ready, sram_re, sram_addr}, {2'b11, 7'h0D});
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            req_valid = 1'b0;
            #1;
            total++;
            if (c == 3) begin
                if (obs_resp !== {1'b1, 32'hDEADBEEF, 2'd2, 3'd5}) begin
                    bad++; $display("FAIL single_resp got=%h want=%h", obs_resp, {1'b1, 32'hDEADBEEF, 2'd2, 3'd5});
                end
            end else if (resp_valid !== 1'b0) begin
                bad++; $display("FAIL single_idle c=%0d got=%b want=0", c, resp_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            resp_ready = 1'b1;
            req_valid  = (c < 8);
            drive_req(c);
            #1;
            if (c < 8) begin
                total++;
                if ({req_ready, sram_re, sram_addr} !== {2'b11, k_addr(c)}) begin
                    bad++; $display("FAIL b2b_accept c=%0d got=%h want=%h", c, {req_ready, sram_re, sram_addr}, {2'b11, k_addr(c)});
                end
            end
            total++;
            if (c >= 3 && c < 11) begin
                if (obs_resp !== exp_resp(c - 3)) begin
                    bad++; $display("FAIL b2b_resp c=%0d got=%h want=%h", c, obs_resp, exp_resp(c - 3));
                end
            end else if (resp_valid !== 1'b0) begin
                bad++; $display("FAIL b2b_idle c=%0d got=%b want=0", c, resp_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            resp_ready = 1'b0; req_valid = 1'b1;
            drive_req(16 + acc);
            #1;
            total++;
            if (req_ready !== (c < 4)) begin
                bad++; $display("FAIL bp_ready c=%0d got=%b want=%b", c, req_ready, (c < 4));
            end
            if (req_ready === 1'b1) acc++;
            total++;
            if (c >= 3) begin
                if (obs_resp !== exp_resp(16)) begin
                    bad++; $display("FAIL bp_hold c=%0d got=%h want=%h", c, obs_resp, exp_resp(16));
                end
            end else if (resp_valid !== 1'b0) begin
                bad++; $display("FAIL bp_early c=%0d got=%b want=0", c, resp_valid);
            end
        end
        total++;
        if (acc != 4) begin
            bad++; $display("FAIL bp_accepted got=%0d want=4", acc);
        end
        for (int c = 8; c <= 12; c++) begin
            @(negedge clock);
            req_valid = 1'b0; resp_ready = 1'b1;
            #1;
            total++;
            if (req_ready !== (c != 8)) begin
                bad++; $display("FAIL bp_ready_return c=%0d got=%b want=%b", c, req_ready, (c != 8));
            end
            total++;
            if (c <= 11) begin
                if (obs_resp !== exp_resp(16 + c - 8)) begin
                    bad++; $display("FAIL bp_drain c=%0d got=%h want=%h", c, obs_resp, exp_resp(16 + c - 8));
                end
            end else if (resp_valid !== 1'b0) begin
                bad++; $display("FAIL bp_empty got=%b want=0", resp_valid);
            end
        end
    endtask

    task automatic test_write_conflict();
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            resp_ready = 1'b1;
            write_busy = (c < 3);
            req_valid  = (c < 4);
            drive_req(32);
            #1;
            total++;
            if (c < 3) begin
                if ({req_ready, sram_re} !== 2'b00) begin
                    bad++; $display("FAIL wb_block c=%0d got=%b want=00", c, {req_ready, sram_re});
                end
            end else if (c == 3) begin
                if ({req_ready, sram_re, sram_addr} !== {2'b11, k_addr(32)}) begin
                    bad++; $display("FAIL wb_accept got=%h want=%h", {req_ready, sram_re, sram_addr}, {2'b11, k_addr(32)});
                end
            end else if (c == 6) begin
                if (obs_resp !== exp_resp(32)) begin
                    bad++; $display("FAIL wb_resp got=%h want=%h", obs_resp, exp_resp(32));
                end
            end else if (resp_valid !== 1'b0) begin
                bad++; $display("FAIL wb_idle c=%0d got=%b want=0", c, resp_valid);
            end
        end
    endtask

    task automatic test_push_pop_full();
        int acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            resp_ready = (c >= 4);
            req_valid  = (c <= 5);
            drive_req(40 + acc);
            #1;
            if (c <= 5) begin
                total++;
                if (req_ready !== (c != 4)) begin
                    bad++; $display("FAIL pp_ready c=%0d got=%b want=%b", c, req_ready, (c != 4));
                end
                if (req_ready === 1'b1) acc++;
            end
            if (c == 4 || c == 5) begin
                total++;
                if (dut.count !== 3'd2) begin
                    bad++; $display("FAIL pp_count c=%0d got=%0d want=2", c, dut.count);
                end
            end
            if (c >= 4) begin
                total++;
                if (c <= 8) begin
                    if (obs_resp !== exp_resp(40 + c - 4)) begin
                        bad++; $display("FAIL pp_resp c=%0d got=%h want=%h", c, obs_resp, exp_resp(40 + c - 4));
                    end
                end else if (resp_valid !== 1'b0) begin
                    bad++; $display("FAIL pp_empty got=%b want=0", resp_valid);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            resp_ready = 1'b0; req_valid = 1'b1;
            drive_req(48 + acc);
            #1;
            if (req_ready === 1'b1) acc++;
        end
        total++;
        if (acc != 4) begin
            bad++; $display("FAIL rm_fill got=%0d want=4", acc);
        end
        for (int c = 4; c < 6; c++) begin
            @(negedge clock);
            reset = 1'b0;
            #1;
            total++;
            if ({req_ready, sram_re, resp_valid} !== 3'b000) begin
                bad++; $display("FAIL rm_in_reset c=%0d got=%b want=000", c, {req_ready, sram_re, resp_valid});
            end
        end
        @(negedge clock);
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        for (int c = 7; c < 11; c++) begin
            @(negedge clock);
            #1;
            total++;
            if ({req_ready, resp_valid} !== 2'b10) begin
                bad++; $display("FAIL rm_no_stale c=%0d got=%b want=10", c, {req_ready, resp_valid});
            end
        end
        @(negedge clock);
        req_valid = 1'b1;
        drive_req(56);
        #1;
        total++;
        if ({req_ready, sram_re, sram_addr} !== {2'b11, k_addr(56)}) begin
            bad++; $display("FAIL rm_fresh_accept got=%h want=%h", {req_ready, sram_re, sram_addr}, {2'b11, k_addr(56)});
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            req_valid = 1'b0;
            #1;
            total++;
            if (c == 3) begin
                if (obs_resp !== exp_resp(56)) begin
                    bad++; $display("FAIL rm_fresh_resp got=%h want=%h", obs_resp, exp_resp(56));
                end
            end else if (resp_valid !== 1'b0) begin
                bad++; $display("FAIL rm_fresh_early c=%0d got=%b want=0", c, resp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        idle(4);
        test_back_to_back();
        idle(4);
        test_backpressure();
        idle(4);
        test_write_conflict();
        idle(4);
        test_push_pop_full();
        idle(4);
        test_reset_mid();
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vrf_read_responder.md
Name: vrf_read_responder

Overview:
- Responder end of the VRF read-request handshake: accepts one VRFReadRequest per cycle from the lane read arbiter and issues the read to the lane's VRF SRAM bank.
- Tracks reads in flight through the fixed-latency SRAM and returns data tagged with readSource/instructionIndex through a response queue with ready/valid.
- Backpressure on the response side never drops data: request acceptance is credit-limited.

Parameters:
- VS_W, 5, vector register index width
- OFFSET_W, 2, offset-within-register width
- SRC_W, 2, readSource tag width
- IDX_W, 3, instructionIndex width
- DATA_W, 32, read data width per lane
- READ_LATENCY, 2, SRAM cycles from sram_re to sram_rdata valid (>=1)
- RESP_DEPTH, 4, response queue entries (>= READ_LATENCY+1)

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_valid  in  1  request present
- req_vs  in  VS_W  vector register
- req_readSource  in  SRC_W  requester tag
- req_offset  in  OFFSET_W  offset within register
- req_instructionIndex  in  IDX_W  owning instruction
- write_busy  in  1  VRF write port owns the bank this cycle
- sram_re  out  1  SRAM read enable
- sram_addr  out  VS_W+OFFSET_W  SRAM address = {req_vs, req_offset}
- sram_rdata  in  DATA_W  SRAM read data, valid READ_LATENCY cycles after sram_re
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_W  read data
- resp_readSource  out  SRC_W  echoed tag
- resp_instructionIndex  out  IDX_W  echoed tag

Behaviour:
- Reset (reset low, async): pipeline valid bits, queue pointers, count and inflight cleared; req_ready=0, sram_re=0, resp_valid=0. In-flight reads are discarded. Data outputs are don't-care while resp_valid=0.
- credit = inflight + count, both registered. req_ready = !write_busy && (credit < RESP_DEPTH). There is no same-cycle pop credit and no combinational path from resp_ready to req_ready.
- Accept (fire) = req_valid && req_ready in cycle T.
  - sram_re = fire and sram_addr = {req_vs, req_offset}, both combinational in cycle T.
  - The tag {readSource, instructionIndex} enters a READ_LATENCY-deep shift pipeline.
- Stage READ_LATENCY valid in cycle T+READ_LATENCY: sram_rdata and the tag are written into the queue at the end of that cycle.
- resp_valid rises in T+READ_LATENCY+1. Minimum latency is READ_LATENCY+1 cycles.
- Queue is a circular FIFO with RESP_DEPTH entries. Pointers wrap modulo RESP_DEPTH. Responses leave in request order.
- Pop = resp_valid && resp_ready. Push and pop in the same cycle leave count unchanged. Push when full is impossible by construction; verification asserts this.
- inflight: +1 on fire, -1 on pipeline exit. Both in the same cycle leave it unchanged.
- While write_busy is high no request is accepted; the pipeline and queue keep draining.
- Throughput: 1 request/cycle sustained while resp_ready stays high and write_busy stays low.
- Response outputs hold stable while resp_valid && !resp_ready.

Decomposition:
- Shared package vrf_pkg:
  - field widths (VS_W, SRC_W, OFFSET_W, IDX_W, DATA_W)
  - packed struct vrf_read_req_t {vs, readSource, offset, instructionIndex}
  - packed struct vrf_read_resp_t {data, readSource, instructionIndex}
- One sub-module: vrf_resp_fifo, a parameterised circular FIFO (width, depth) exposing count, with push/pop/full/empty.

Test Plan:
- Single read: reset released, req vs=3 offset=1 src=2 idx=5; SRAM returns 0xDEADBEEF -> sram_addr=0x0D in accept cycle, resp_valid exactly 3 cycles later with data 0xDEADBEEF, src=2, idx=5.
- Back-to-back: 8 requests on consecutive cycles, resp_ready=1 -> req_ready never drops; 8 responses on 8 consecutive cycles in order.
- Backpressure: resp_ready=0, issue requests continuously -> exactly 4 accepted, then req_ready=0; raise resp_ready -> queue drains in order, req_ready returns the cycle after the first pop, no loss or duplication.
- Write conflict: write_busy=1 for 3 cycles with req_valid held -> no sram_re during those cycles; accepted on the first cycle write_busy=0.
- Simultaneous push/pop with full credit: count stays constant and req_ready follows registered credit only.
- Reset mid-operation: assert reset with 2 in flight and 2 queued -> all outputs low immediately; after release no stale resp_valid, and a fresh request completes normally.
